// File: rtl/trakball_decoder.sv
// Trackball quadrature decoder with button emulation.
// Produces the packed {v_cnt, h_cnt} word for the centipede core from two
// asynchronous A/B encoder axes, or from the active-low board buttons.
module trakball_decoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned EMU_DIV    = 120000,
    parameter bit          EMU_EN     = 1'b1
) (
    input  logic       clk12m,
    input  logic       reset_n,
    input  logic       h_a_i,
    input  logic       h_b_i,
    input  logic       v_a_i,
    input  logic       v_b_i,
    input  logic       emu_left_n,
    input  logic       emu_right_n,
    input  logic       emu_up_n,
    input  logic       emu_down_n,
    input  logic       err_clr_i,
    output logic [7:0] trakball_o,
    output logic       h_dir_o,
    output logic       v_dir_o,
    output logic       h_err_o,
    output logic       v_err_o
);

    localparam int unsigned FCW      = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam int unsigned DW       = (EMU_DIV < 2) ? 1 : $clog2(EMU_DIV);
    localparam int unsigned NSYNC    = 8;
    localparam logic [2:0]  PRIME_END = 3'd4;

    // Gray state {A,B} to position 0..3 along the forward sequence 00,01,11,10.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // Buttons are inverted before sync so a cleared synchroniser reads "released".
    logic [NSYNC-1:0] raw;
    logic [NSYNC-1:0] sync1_q;
    logic [NSYNC-1:0] sync2_q;

    assign raw = {~emu_down_n, ~emu_up_n, ~emu_right_n, ~emu_left_n,
                  v_b_i, v_a_i, h_b_i, h_a_i};

    // Two-flop synchronisers on every asynchronous input.
    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Post-reset priming: the first settled A/B state becomes the reference silently.
    logic [2:0] prime_q;
    logic [2:0] prime_d;
    logic       priming;

    assign priming = (prime_q != PRIME_END);

    // Priming counter next state.
    always_comb begin
        prime_d = prime_q;
        if (priming) begin
            prime_d = prime_q + 3'd1;
        end
    end

    // Priming counter register.
    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            prime_q <= '0;
        end else begin
            prime_q <= prime_d;
        end
    end

    // Filtered A/B levels: [0]=h_a [1]=h_b [2]=v_a [3]=v_b.
    logic [3:0] filt;

    for (genvar i = 0; i < 4; i++) begin : g_filt
        if (FILTER_LEN == 0) begin : g_bypass
            assign filt[i] = sync2_q[i];
        end else begin : g_filter
            logic           fq_q;
            logic           fq_d;
            logic [FCW-1:0] cnt_q;
            logic [FCW-1:0] cnt_d;

            // Accept a new level only after FILTER_LEN consecutive differing samples.
            always_comb begin
                fq_d  = fq_q;
                cnt_d = '0;
                if (priming) begin
                    fq_d = sync2_q[i];
                end else if (sync2_q[i] != fq_q) begin
                    if (cnt_q == FCW'(FILTER_LEN - 1)) begin
                        fq_d = sync2_q[i];
                    end else begin
                        cnt_d = cnt_q + FCW'(1);
                    end
                end
            end

            // Filter state register.
            always_ff @(posedge clk12m or negedge reset_n) begin
                if (!reset_n) begin
                    fq_q  <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    fq_q  <= fq_d;
                    cnt_q <= cnt_d;
                end
            end

            assign filt[i] = fq_q;
        end
    end

    // Per-axis decode, emulation and counting: ax 0 = horizontal, ax 1 = vertical.
    for (genvar ax = 0; ax < 2; ax++) begin : g_axis
        logic [1:0]        cur;
        logic [1:0]        ref_q;
        logic [1:0]        step;
        logic              illegal;
        logic signed [2:0] enc_delta;
        logic signed [2:0] emu_delta;
        logic signed [2:0] net_delta;
        logic [3:0]        cnt_q;
        logic [3:0]        cnt_d;
        logic              dir_q;
        logic              dir_d;
        logic              err_q;
        logic              err_d;

        assign cur = {filt[2*ax], filt[2*ax+1]};

        // Quadrature step classification against the reference state.
        always_comb begin
            step      = gray_pos(cur) - gray_pos(ref_q);
            enc_delta = 3'sb000;
            illegal   = 1'b0;
            if (!priming) begin
                case (step)
                    2'd1:    enc_delta = 3'sb001;
                    2'd3:    enc_delta = 3'sb111;
                    2'd2:    illegal   = 1'b1;
                    default: ;
                endcase
            end
        end

        if (EMU_EN) begin : g_emu
            logic          plus;
            logic          minus;
            logic          active;
            logic [DW-1:0] div_q;
            logic [DW-1:0] div_d;

            assign minus  = sync2_q[4 + 2*ax];
            assign plus   = sync2_q[5 + 2*ax];
            assign active = plus ^ minus;

            // Step on the first held cycle, then every EMU_DIV cycles; idle holds divider at 0.
            always_comb begin
                div_d     = '0;
                emu_delta = 3'sb000;
                if (active) begin
                    if (div_q == '0) begin
                        emu_delta = minus ? 3'sb111 : 3'sb001;
                    end
                    div_d = (div_q == DW'(EMU_DIV - 1)) ? '0 : div_q + DW'(1);
                end
            end

            // Emulation divider register.
            always_ff @(posedge clk12m or negedge reset_n) begin
                if (!reset_n) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_d;
                end
            end
        end else begin : g_no_emu
            assign emu_delta = 3'sb000;
        end

        // Combine deltas into the modulo-16 count, direction and sticky error.
        always_comb begin
            net_delta = enc_delta + emu_delta;
            cnt_d     = cnt_q + {net_delta[2], net_delta};
            dir_d     = dir_q;
            if (net_delta != 3'sb000) begin
                dir_d = net_delta[2];
            end
            err_d = err_q;
            if (err_clr_i) begin
                err_d = 1'b0;
            end
            if (illegal) begin
                err_d = 1'b1;
            end
        end

        // Axis state registers.
        always_ff @(posedge clk12m or negedge reset_n) begin
            if (!reset_n) begin
                ref_q <= '0;
                cnt_q <= '0;
                dir_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                ref_q <= cur;
                cnt_q <= cnt_d;
                dir_q <= dir_d;
                err_q <= err_d;
            end
        end
    end

    assign trakball_o = {g_axis[1].cnt_q, g_axis[0].cnt_q};
    assign h_dir_o    = g_axis[0].dir_q;
    assign v_dir_o    = g_axis[1].dir_q;
    assign h_err_o    = g_axis[0].err_q;
    assign v_err_o    = g_axis[1].err_q;

endmodule
